// File: rtl/rv_g_regfile_mwb.sv
// rv_g_regfile_mwb: unified RV-G integer/FP register file with multiple write-back
// ports, three read ports and a lock scoreboard gating issue.
module rv_g_regfile_mwb #(
    parameter int XLEN             = 64,
    parameter int FLEN             = 64,
    parameter int NUM_WR           = 2,
    parameter int ALLOW_FORWARDING = 1,
    localparam int MaxLen          = (XLEN > FLEN) ? XLEN : FLEN
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_WR-1:0][5:0]         wr_addr_i,
    input  logic [NUM_WR-1:0][MaxLen-1:0]  wr_data_i,
    input  logic [NUM_WR-1:0]              wr_en_i,
    input  logic [5:0]                     rd_addr_i,
    input  logic [5:0]                     rs1_addr_i,
    input  logic [5:0]                     rs2_addr_i,
    input  logic [5:0]                     rs3_addr_i,
    input  logic                           req_i,
    input  logic                           flush_i,
    output logic [MaxLen-1:0]              rs1_data_o,
    output logic [MaxLen-1:0]              rs2_data_o,
    output logic [MaxLen-1:0]              rs3_data_o,
    output logic                           gnt_o,
    output logic [63:0]                    lock_o
);
    logic [MaxLen-1:0] regs_q [64];
    logic [MaxLen-1:0] regs_d [64];
    logic [63:0]       lock_q, lock_d, wr_hit, eff;
    logic [5:0]        rs_addr [3];
    logic [MaxLen-1:0] rs_data [3];

    // Truncate to the target register's width and zero-extend back to the port width.
    function automatic logic [MaxLen-1:0] fit(input logic [5:0] a, input logic [MaxLen-1:0] d);
        fit = '0;
        if (a[5]) fit[FLEN-1:0] = d[FLEN-1:0];
        else      fit[XLEN-1:0] = d[XLEN-1:0];
    endfunction

    always_comb begin
        wr_hit = '0;
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) begin
                wr_hit[wr_addr_i[p]] = 1'b1;
                if (wr_addr_i[p] != 6'd0) regs_d[wr_addr_i[p]] = fit(wr_addr_i[p], wr_data_i[p]);
            end
        end
    end

    // Ascending port order lets the highest-index writer win forwarding.
    always_comb begin
        rs_addr[0] = rs1_addr_i;
        rs_addr[1] = rs2_addr_i;
        rs_addr[2] = rs3_addr_i;
        for (int s = 0; s < 3; s++) begin
            rs_data[s] = (rs_addr[s] == 6'd0) ? '0 : regs_q[rs_addr[s]];
            for (int p = 0; p < NUM_WR; p++) begin
                if (ALLOW_FORWARDING != 0 && wr_en_i[p] && wr_addr_i[p] == rs_addr[s] && rs_addr[s] != 6'd0)
                    rs_data[s] = fit(wr_addr_i[p], wr_data_i[p]);
            end
        end
    end

    assign rs1_data_o = rs_data[0];
    assign rs2_data_o = rs_data[1];
    assign rs3_data_o = rs_data[2];

    // Set after clear so a grant on a register being released re-locks it.
    always_comb begin
        eff    = lock_q & ~((ALLOW_FORWARDING != 0) ? wr_hit : 64'd0);
        gnt_o  = rst_ni & req_i & ~flush_i & ~eff[rs1_addr_i] & ~eff[rs2_addr_i]
               & ~eff[rs3_addr_i] & ~eff[rd_addr_i];
        lock_d = flush_i ? 64'd0 : (lock_q & ~wr_hit);
        if (gnt_o) lock_d[rd_addr_i] = 1'b1;
        lock_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
            lock_q <= '0;
        end else begin
            regs_q <= regs_d;
            lock_q <= lock_d;
        end
    end

    assign lock_o = lock_q;
endmodule

// File: tb/tb_rv_g_regfile_mwb.sv
// tb_rv_g_regfile_mwb: two configurations (64/64 forwarding, 32/64 no forwarding) share
// one stimulus stream and are checked every cycle against a behavioural model.
module tb_rv_g_regfile_mwb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, req, flush;
    logic [1:0][5:0]  wa;
    logic [1:0][63:0] wd;
    logic [1:0]       we;
    logic [5:0]       rd, rs1, rs2, rs3;
    logic [63:0]      a_rs1, a_rs2, a_rs3, a_lock, b_rs1, b_rs2, b_rs3, b_lock;
    logic             a_gnt, b_gnt;

    int checks = 0, failures = 0;
    bit check_en = 0;

    rv_g_regfile_mwb #(.XLEN(64), .FLEN(64), .NUM_WR(2), .ALLOW_FORWARDING(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .wr_addr_i(wa), .wr_data_i(wd), .wr_en_i(we),
        .rd_addr_i(rd), .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs3_addr_i(rs3),
        .req_i(req), .flush_i(flush), .rs1_data_o(a_rs1), .rs2_data_o(a_rs2),
        .rs3_data_o(a_rs3), .gnt_o(a_gnt), .lock_o(a_lock));

    rv_g_regfile_mwb #(.XLEN(32), .FLEN(64), .NUM_WR(2), .ALLOW_FORWARDING(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .wr_addr_i(wa), .wr_data_i(wd), .wr_en_i(we),
        .rd_addr_i(rd), .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs3_addr_i(rs3),
        .req_i(req), .flush_i(flush), .rs1_data_o(b_rs1), .rs2_data_o(b_rs2),
        .rs3_data_o(b_rs3), .gnt_o(b_gnt), .lock_o(b_lock));

    // Model: index 0 = dut_a, index 1 = dut_b.
    logic [63:0] m_regs [2][64];
    logic [63:0] m_lock [2];
    int xl [2] = '{64, 32};
    bit fw [2] = '{1'b1, 1'b0};

    function automatic logic [63:0] trunc(int k, logic [5:0] a, logic [63:0] d);
        int w;
        w = a[5] ? 64 : xl[k];
        return (w == 64) ? d : (d & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic bit written(logic [5:0] a);
        for (int p = 0; p < 2; p++) if (we[p] && wa[p] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] exp_rd(int k, logic [5:0] a);
        logic [63:0] v;
        if (a == 6'd0) return 64'd0;
        v = m_regs[k][a];
        if (fw[k]) for (int p = 0; p < 2; p++) if (we[p] && wa[p] == a) v = trunc(k, a, wd[p]);
        return v;
    endfunction

    function automatic bit blk(int k, logic [5:0] a);
        return m_lock[k][a] && !(fw[k] && written(a));
    endfunction

    function automatic bit exp_gnt(int k);
        return rst_n && req && !flush && !blk(k, rs1) && !blk(k, rs2) && !blk(k, rs3) && !blk(k, rd);
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [63:0] nl;
        bit g;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int i = 0; i < 64; i++) m_regs[k][i] <= 64'd0;
                m_lock[k] <= 64'd0;
            end else begin
                g  = exp_gnt(k);
                nl = m_lock[k];
                for (int p = 0; p < 2; p++) begin
                    if (we[p]) begin
                        nl[wa[p]] = 1'b0;
                        if (wa[p] != 6'd0) m_regs[k][wa[p]] <= trunc(k, wa[p], wd[p]);
                    end
                end
                if (flush) nl = 64'd0;
                if (g && rd != 6'd0) nl[rd] = 1'b1;
                nl[0] = 1'b0;
                m_lock[k] <= nl;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("a_rs1", a_rs1, exp_rd(0, rs1));
            chk("a_rs2", a_rs2, exp_rd(0, rs2));
            chk("a_rs3", a_rs3, exp_rd(0, rs3));
            chk("a_gnt", {63'd0, a_gnt}, {63'd0, exp_gnt(0)});
            chk("a_lock", a_lock, m_lock[0]);
            chk("b_rs1", b_rs1, exp_rd(1, rs1));
            chk("b_rs2", b_rs2, exp_rd(1, rs2));
            chk("b_rs3", b_rs3, exp_rd(1, rs3));
            chk("b_gnt", {63'd0, b_gnt}, {63'd0, exp_gnt(1)});
            chk("b_lock", b_lock, m_lock[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; req = 0; flush = 0;
        rd = 0; rs1 = 0; rs2 = 0; rs3 = 0;
    endtask

    function automatic logic [5:0] pick();
        case ($urandom_range(0, 9))
            0: return 6'd0;
            1: return 6'd1;
            2: return 6'd5;
            3: return 6'd7;
            4: return 6'd9;
            5: return 6'd32;
            6: return 6'd35;
            7: return 6'd63;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        rst_n = 0;
        cyc();
        check_en = 1;
        cyc();
        @(negedge clk);
        chk("rst_lock", a_lock, 64'd0);
        chk("rst_gnt", {63'd0, a_gnt}, 64'd0);
        #1 rst_n = 1;
        // Test 1: write then read next cycle
        we[0] = 1; wa[0] = 6'd5; wd[0] = 64'h1234;
        cyc();
        idle(); rs1 = 6'd5;
        @(negedge clk);
        chk("t1_a_rs1", a_rs1, 64'h1234);
        chk("t1_b_rs1", b_rs1, 64'h1234);
        // Test 2: x0 write ignored, rd=0 never locks
        cyc();
        idle(); we[0] = 1; wa[0] = 6'd0; wd[0] = 64'hFFFF; req = 1;
        @(negedge clk);
        chk("t2_gnt", {63'd0, a_gnt}, 64'd1);
        chk("t2_rs1_fwd", a_rs1, 64'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("t2_rs1", a_rs1, 64'd0);
        chk("t2_lock0", {63'd0, a_lock[0]}, 64'd0);
        // Test 3: lock f3, then RAW stall until write-back
        cyc();
        idle(); req = 1; rd = 6'd35;
        cyc();
        rd = 6'd1; rs2 = 6'd35;
        @(negedge clk);
        chk("t3_lock35", {63'd0, a_lock[35]}, 64'd1);
        chk("t3_a_stall", {63'd0, a_gnt}, 64'd0);
        chk("t3_b_stall", {63'd0, b_gnt}, 64'd0);
        cyc();
        we[0] = 1; wa[0] = 6'd35; wd[0] = 64'h77;
        @(negedge clk);
        chk("t3_a_fwd_gnt", {63'd0, a_gnt}, 64'd1);
        chk("t3_b_nofwd", {63'd0, b_gnt}, 64'd0);
        chk("t3_a_fwd_data", a_rs2, 64'h77);
        cyc();
        we = '0;
        @(negedge clk);
        chk("t3_b_gnt", {63'd0, b_gnt}, 64'd1);
        chk("t3_b_data", b_rs2, 64'h77);
        chk("t3_a_waw", {63'd0, a_gnt}, 64'd0);
        cyc();
        idle(); we[0] = 1; wa[0] = 6'd1;
        cyc();
        // Test 4: two-port collision
        idle(); we = 2'b11; wa[0] = 6'd7; wa[1] = 6'd7; wd[0] = 64'hA; wd[1] = 64'hB; rs3 = 6'd7;
        @(negedge clk);
        chk("t4_fwd", a_rs3, 64'hB);
        cyc();
        we = '0;
        @(negedge clk);
        chk("t4_a_store", a_rs3, 64'hB);
        chk("t4_b_store", b_rs3, 64'hB);
        // Test 5: integer truncation with XLEN=32
        cyc();
        idle(); we[0] = 1; wa[0] = 6'd1; wd[0] = 64'hDEADBEEF_CAFEF00D;
        cyc();
        idle(); rs1 = 6'd1;
        @(negedge clk);
        chk("t5_b_trunc", b_rs1, 64'h00000000_CAFEF00D);
        chk("t5_a_full", a_rs1, 64'hDEADBEEF_CAFEF00D);
        // Test 6: flush and mid-run reset
        cyc();
        idle(); req = 1; rd = 6'd9;
        cyc();
        rd = 6'd10;
        cyc();
        idle();
        @(negedge clk);
        chk("t6_locks", a_lock & 64'h600, 64'h600);
        cyc();
        flush = 1; req = 1; rd = 6'd11;
        @(negedge clk);
        chk("t6_flush_gnt", {63'd0, a_gnt}, 64'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("t6_a_flushed", a_lock, 64'd0);
        chk("t6_b_flushed", b_lock, 64'd0);
        cyc();
        req = 1; rd = 6'd9;
        cyc();
        idle(); rst_n = 0; rs1 = 6'd1;
        cyc();
        rst_n = 1;
        @(negedge clk);
        chk("t6_rst_lock", a_lock, 64'd0);
        chk("t6_rst_data", a_rs1, 64'd0);
        // Randomised traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                we[p] = ($urandom_range(0, 2) == 0);
                wa[p] = pick();
                wd[p] = {$urandom, $urandom};
            end
            req   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            rd = pick(); rs1 = pick(); rs2 = pick(); rs3 = pick();
        end
        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
